pipeline_if_id_reg: RTL and testbench
=====================================

// Module: pipeline_if_id_reg
// PURPOSE
//  IF/ID boundary register of the 5-stage RISC-V pipeline. Captures PC, PC+4 and fetched instruction from the IF stage,
//  presents them to ID one cycle later. Holds on hazard stall, injects NOP bubble on taken branch/jump (PCSrc flush),
//  and absorbs the one in-flight instruction memory word via a 1-entry skid buffer; drives the IF stage PC enable.
// PARAMETERS
//  XLEN      32             datapath / PC width
//  NOP_INST  32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//  clk_IFID        in   1     pipeline clock; all state updates on rising edge
//  rst_IFID        in   1     synchronous, active-high reset
//  PC_in_IFID      in   XLEN  PC of fetched word (IF stage PC register output)
//  inst_in_IFID    in   32    instruction word from instruction memory
//  inst_vld_IFID   in   1     inst_in_IFID/PC_in_IFID valid this cycle
//  stall_IFID      in   1     hazard unit: hold ID contents
//  flush_IFID      in   1     taken branch/jump (PCSrc): discard fetched word
//  en_IF_out       out  1     PC register enable for IF stage
//  PC_out_IFID     out  XLEN  registered PC to ID
//  PC4_out_IFID    out  XLEN  registered PC+4 to ID
//  inst_out_IFID   out  32    registered instruction to ID
//  valid_out_IFID  out  1     ID slot holds a real instruction
//  ovf_err_IFID    out  1     sticky: word arrived while skid full
//  stall_cnt/flush_cnt/bubble_cnt  out 32 each  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sync, rst_IFID=1 at edge): PC/PC4 outs=0, inst_out=NOP_INST, valid=0, skid empty, ovf_err=0, counters=0.
//  en_IF_out = ~rst_IFID & ~stall_IFID & ~skid_full (combinational).
//  PC4 = PC_in_IFID + 4, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0x0). Latency in -> out: 1 cycle.
//  Per rising edge, priority order:
//   1 rst: reset values above (overrides everything, incl. mid-stall/skid full).
//   2 flush: main <= {PC=0,PC4=0,NOP_INST,valid=0}; skid emptied; incoming word dropped. Flush beats stall.
//   3 stall: main holds. If inst_vld & skid empty -> skid <= {PC,PC4,inst}. If inst_vld & skid full -> drop, ovf_err<=1.
//   4 no stall, skid full: main <= skid (valid=1); skid <= incoming if inst_vld else empty.
//   5 no stall, skid empty: main <= {incoming, valid=inst_vld}; inst=NOP_INST when inst_vld=0.
//  Skid FSM: EMPTY -(stall & inst_vld & ~flush)-> FULL; FULL -(~stall & ~inst_vld | flush)-> EMPTY.
//  Upstream contract: inst_vld only the cycle after en_IF_out=1 (1-cycle imem); ovf_err flags violation.
//  ovf_err sticky until reset. No reordering: skid word always precedes later words.
// CONFIGURATION
//  IFID_PERF_CNT_EN defined: stall_cnt += 1 per cycle stall_IFID & ~flush; flush_cnt += 1 per flush cycle;
//   bubble_cnt += 1 per cycle valid_out_IFID=0 after reset; all wrap at 2^32, reset to 0.
//  Undefined: counter regs not built; the three ports tied to 32'h0.
// STRUCTURE
//  pipeline_pkg: NOP_INST constant, XLEN, typedef if_id_t {pc, pc4, inst, valid} shared with ID/EX stages.
//  Sub-module ifid_skid_buf: 1-entry holding if_id_t + full flag, load/drain/clear controls.
//  Top: main register, PC+4 adder, priority mux, en_IF_out logic, optional counters.
// TESTING
//  Reset: rst 2 cycles with inst_vld=1 -> valid=0, inst_out=0x13, en_IF_out=0 during rst, =1 cycle after.
//  Stream: PC 0x0,0x4,0x8 with insts A,B,C, no stall -> outputs A@0x0 (PC4 0x4), B, C each 1 cycle later.
//  Stall+skid: stall 3 cycles as B arrives -> out holds A, skid=B, en_IF_out=0; release -> B then C, no loss.
//  Flush vs stall: flush=stall=1 with skid full -> valid=0, inst=0x13, skid empty, en_IF_out=1 next cycle.
//  Wrap/overflow: PC 0xFFFF_FFFC -> PC4_out=0x0; 2nd inst_vld while skid full under stall -> ovf_err=1, sticky.
//  IFID_PERF_CNT_EN: 4 stall cycles + 2 flushes -> stall_cnt=4, flush_cnt=2; macro off -> all counters read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and the IF/ID payload type used by the
// IF/ID register and by the ID/EX stages downstream.
package pipeline_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [31:0]     inst;
      logic            valid;
   } if_id_t;

   typedef enum logic {SKID_EMPTY = 1'b0, SKID_FULL = 1'b1} skid_state_e;

   // Bubble slot content: zero PCs, NOP encoding, not valid.
   function automatic if_id_t bubble();
      if_id_t b;
      b.pc    = '0;
      b.pc4   = '0;
      b.inst  = NOP_INST;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/ifid_skid_buf.sv
// ifid_skid_buf: one-entry holding register for the instruction word that is
// already in flight from instruction memory when the pipeline stalls.
// clear_i wins over load_i; load_i and clear_i are never asserted together by
// the IF/ID register, but the priority keeps the buffer well defined anyway.
module ifid_skid_buf
   import pipeline_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   load_i,
   input  logic   clear_i,
   input  if_id_t data_i,
   output if_id_t data_o,
   output logic   full_o
);

   skid_state_e state_q, state_d;
   if_id_t      data_q,  data_d;

   // Occupancy state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= SKID_EMPTY;
      else       state_q <= state_d;
   end

   // Next occupancy and next stored word.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (clear_i) begin
         state_d = SKID_EMPTY;
      end else if (load_i) begin
         state_d = SKID_FULL;
         data_d  = data_i;
      end
   end

   // Stored word register.
   always_ff @(posedge clk_i) begin
      if (rst_i) data_q <= bubble();
      else       data_q <= data_d;
   end

   assign data_o = data_q;
   assign full_o = (state_q == SKID_FULL);

endmodule

// File: rtl/pipeline_if_id_reg.sv
// pipeline_if_id_reg: IF/ID boundary register of the 5-stage RISC-V pipeline.
// Holds on stall, bubbles on flush, parks the in-flight imem word in a
// one-entry skid buffer and drives the IF PC enable.
// Optional feature macro: IFID_PERF_CNT_EN builds the stall/flush/bubble
// performance counters; without it those ports read 32'h0.
module pipeline_if_id_reg
   import pipeline_pkg::*;
(
   input  logic            clk_IFID,
   input  logic            rst_IFID,
   input  logic [XLEN-1:0] PC_in_IFID,
   input  logic [31:0]     inst_in_IFID,
   input  logic            inst_vld_IFID,
   input  logic            stall_IFID,
   input  logic            flush_IFID,
   output logic            en_IF_out,
   output logic [XLEN-1:0] PC_out_IFID,
   output logic [XLEN-1:0] PC4_out_IFID,
   output logic [31:0]     inst_out_IFID,
   output logic            valid_out_IFID,
   output logic            ovf_err_IFID,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt,
   output logic [31:0]     bubble_cnt
);

   if_id_t main_q, main_d;
   if_id_t incoming;
   if_id_t skid_data;
   logic   skid_full;
   logic   skid_load;
   logic   skid_clear;
   logic   ovf_q, ovf_d;

   // Fetched word as an IF/ID slot; PC+4 wraps modulo 2^XLEN.
   always_comb begin
      incoming.pc    = PC_in_IFID;
      incoming.pc4   = PC_in_IFID + XLEN'(4);
      incoming.inst  = inst_vld_IFID ? inst_in_IFID : NOP_INST;
      incoming.valid = inst_vld_IFID;
   end

   // Park the word under stall if room; refill behind a draining skid entry.
   assign skid_load  = ~flush_IFID & inst_vld_IFID &
                       (stall_IFID ? ~skid_full : skid_full);
   // Empty on flush, or when the entry drains with nothing behind it.
   assign skid_clear = flush_IFID | (~stall_IFID & skid_full & ~inst_vld_IFID);

   ifid_skid_buf u_skid (
      .clk_i   (clk_IFID),
      .rst_i   (rst_IFID),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (incoming),
      .data_o  (skid_data),
      .full_o  (skid_full)
   );

   // PC stops while stalled or while the skid entry still has to drain.
   assign en_IF_out = ~rst_IFID & ~stall_IFID & ~skid_full;

   // Main slot next value: flush > stall > skid drain > direct capture.
   always_comb begin
      main_d = main_q;
      if (flush_IFID) begin
         main_d = bubble();
      end else if (stall_IFID) begin
         main_d = main_q;
      end else if (skid_full) begin
         main_d       = skid_data;
         main_d.valid = 1'b1;
      end else begin
         main_d = incoming;
      end
   end

   // Main slot register.
   always_ff @(posedge clk_IFID) begin
      if (rst_IFID) main_q <= bubble();
      else          main_q <= main_d;
   end

   // Sticky overflow: a word arrived under stall with the skid already full.
   assign ovf_d = ovf_q | (~flush_IFID & stall_IFID & inst_vld_IFID & skid_full);

   // Overflow flag register.
   always_ff @(posedge clk_IFID) begin
      if (rst_IFID) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign PC_out_IFID    = main_q.pc;
   assign PC4_out_IFID   = main_q.pc4;
   assign inst_out_IFID  = main_q.inst;
   assign valid_out_IFID = main_q.valid;
   assign ovf_err_IFID   = ovf_q;

`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;
   logic [31:0] stall_cnt_d, flush_cnt_d, bubble_cnt_d;

   // Counter increments; all wrap at 2^32.
   always_comb begin
      stall_cnt_d  = stall_cnt_q  + {31'd0, stall_IFID & ~flush_IFID};
      flush_cnt_d  = flush_cnt_q  + {31'd0, flush_IFID};
      bubble_cnt_d = bubble_cnt_q + {31'd0, ~main_q.valid};
   end

   // Performance counter registers.
   always_ff @(posedge clk_IFID) begin
      if (rst_IFID) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'h0;
   assign flush_cnt  = 32'h0;
   assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_if_id_reg.sv
// tb_pipeline_if_id_reg: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
// Honours IFID_PERF_CNT_EN the same way the design does.
module tb_pipeline_if_id_reg;

   logic        clk_IFID = 1'b0;
   logic        rst_IFID = 1'b1;
   logic [31:0] PC_in_IFID = '0;
   logic [31:0] inst_in_IFID = '0;
   logic        inst_vld_IFID = 1'b0;
   logic        stall_IFID = 1'b0;
   logic        flush_IFID = 1'b0;
   logic        en_IF_out;
   logic [31:0] PC_out_IFID, PC4_out_IFID, inst_out_IFID;
   logic        valid_out_IFID, ovf_err_IFID;
   logic [31:0] stall_cnt, flush_cnt, bubble_cnt;

   pipeline_if_id_reg dut (
      .clk_IFID       (clk_IFID),
      .rst_IFID       (rst_IFID),
      .PC_in_IFID     (PC_in_IFID),
      .inst_in_IFID   (inst_in_IFID),
      .inst_vld_IFID  (inst_vld_IFID),
      .stall_IFID     (stall_IFID),
      .flush_IFID     (flush_IFID),
      .en_IF_out      (en_IF_out),
      .PC_out_IFID    (PC_out_IFID),
      .PC4_out_IFID   (PC4_out_IFID),
      .inst_out_IFID  (inst_out_IFID),
      .valid_out_IFID (valid_out_IFID),
      .ovf_err_IFID   (ovf_err_IFID),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt),
      .bubble_cnt     (bubble_cnt)
   );

   always #5 clk_IFID = ~clk_IFID;

   // Reference model: what ID sees, plus the parked words as a queue.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        skq[$];
   logic [31:0] m_pc, m_pc4, m_inst;
   logic        m_valid, m_ovf;
   logic [31:0] m_stall_cnt, m_flush_cnt, m_bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_load(input logic [31:0] pc, input logic [31:0] inst, input logic v);
      m_pc    = pc;
      m_pc4   = pc + 32'd4;
      m_inst  = v ? inst : 32'h13;
      m_valid = v;
   endtask

   // One rising edge applied to the model with the current inputs.
   task automatic model_step();
      ent_t e;
      if (rst_IFID) begin
         m_pc = 0; m_pc4 = 0; m_inst = 32'h13; m_valid = 0; m_ovf = 0;
         skq.delete();
         m_stall_cnt = 0; m_flush_cnt = 0; m_bubble_cnt = 0;
      end else begin
         if (!m_valid) m_bubble_cnt++;
         if (flush_IFID) m_flush_cnt++;
         else if (stall_IFID) m_stall_cnt++;
         e.pc   = PC_in_IFID;
         e.inst = inst_in_IFID;
         if (flush_IFID) begin
            m_pc = 0; m_pc4 = 0; m_inst = 32'h13; m_valid = 0;
            skq.delete();
         end else if (stall_IFID) begin
            if (inst_vld_IFID) begin
               if (skq.size() == 0) skq.push_back(e);
               else m_ovf = 1;
            end
         end else if (skq.size() != 0) begin
            ent_t h;
            h = skq.pop_front();
            model_load(h.pc, h.inst, 1'b1);
            if (inst_vld_IFID) skq.push_back(e);
         end else begin
            model_load(PC_in_IFID, inst_in_IFID, inst_vld_IFID);
         end
      end
   endtask

   task automatic compare();
      chk("PC_out", PC_out_IFID, m_pc);
      chk("PC4_out", PC4_out_IFID, m_pc4);
      chk("inst_out", inst_out_IFID, m_inst);
      chk("valid_out", {31'd0, valid_out_IFID}, {31'd0, m_valid});
      chk("ovf_err", {31'd0, ovf_err_IFID}, {31'd0, m_ovf});
`ifdef IFID_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("flush_cnt", flush_cnt, m_flush_cnt);
      chk("bubble_cnt", bubble_cnt, m_bubble_cnt);
`else
      chk("stall_cnt", stall_cnt, 32'h0);
      chk("flush_cnt", flush_cnt, 32'h0);
      chk("bubble_cnt", bubble_cnt, 32'h0);
`endif
   endtask

   // Drive inputs after the falling edge, check the comb enable, clock once,
   // then check registered outputs on the next falling edge.
   task automatic tick(input logic r, input logic v, input logic s, input logic f,
                       input logic [31:0] pc, input logic [31:0] inst);
      logic exp_en;
      rst_IFID = r; inst_vld_IFID = v; stall_IFID = s; flush_IFID = f;
      PC_in_IFID = pc; inst_in_IFID = inst;
      #1;
      exp_en = ~r & ~s & (skq.size() == 0);
      chk("en_IF_out", {31'd0, en_IF_out}, {31'd0, exp_en});
      @(posedge clk_IFID);
      model_step();
      @(negedge clk_IFID);
      compare();
   endtask

   localparam logic [31:0] A = 32'h0010_0093, B = 32'h0020_0113, C = 32'h0030_0193;
   localparam logic [31:0] D = 32'h0040_0213, E = 32'h0050_0293, F = 32'h0060_0313;

   initial begin
      @(negedge clk_IFID);

      // Reset with a valid word present
      tick(1, 1, 0, 0, 32'h100, 32'hDEAD_BEEF);
      tick(1, 1, 0, 0, 32'h100, 32'hDEAD_BEEF);
      chk("rst valid", {31'd0, valid_out_IFID}, 32'd0);
      chk("rst inst", inst_out_IFID, 32'h13);
      chk("rst en", {31'd0, en_IF_out}, 32'd0);
      tick(0, 0, 0, 0, 32'h0, 32'h0);
      chk("post-rst en", {31'd0, en_IF_out}, 32'd1);

      // Straight stream
      tick(0, 1, 0, 0, 32'h0, A);
      chk("stream PC A", PC_out_IFID, 32'h0);
      chk("stream PC4 A", PC4_out_IFID, 32'h4);
      chk("stream inst A", inst_out_IFID, A);
      tick(0, 1, 0, 0, 32'h4, B);
      chk("stream inst B", inst_out_IFID, B);
      tick(0, 1, 0, 0, 32'h8, C);
      chk("stream inst C", inst_out_IFID, C);
      chk("stream PC C", PC_out_IFID, 32'h8);

      // Stall while B is in flight: B parks, released in order
      tick(0, 1, 0, 0, 32'h0, A);
      tick(0, 1, 1, 0, 32'h4, B);
      tick(0, 0, 1, 0, 32'h0, 32'h0);
      tick(0, 0, 1, 0, 32'h0, 32'h0);
      chk("stall hold A", inst_out_IFID, A);
      chk("stall en", {31'd0, en_IF_out}, 32'd0);
      tick(0, 0, 0, 0, 32'h0, 32'h0);
      chk("release B", inst_out_IFID, B);
      chk("release B PC", PC_out_IFID, 32'h4);
      tick(0, 1, 0, 0, 32'h8, C);
      chk("release C", inst_out_IFID, C);

      // Flush together with stall while skid is full
      tick(0, 1, 0, 0, 32'h0, A);
      tick(0, 1, 1, 0, 32'h4, B);
      tick(0, 0, 1, 1, 32'h0, 32'h0);
      chk("flush valid", {31'd0, valid_out_IFID}, 32'd0);
      chk("flush inst", inst_out_IFID, 32'h13);
      tick(0, 0, 0, 0, 32'h0, 32'h0);
      chk("flush en", {31'd0, en_IF_out}, 32'd1);
      chk("flush skid dropped", {31'd0, valid_out_IFID}, 32'd0);

      // PC+4 wrap, then overflow under stall
      tick(0, 1, 0, 0, 32'hFFFF_FFFC, D);
      chk("wrap PC4", PC4_out_IFID, 32'h0);
      tick(0, 1, 1, 0, 32'h0, E);
      tick(0, 1, 1, 0, 32'h4, F);
      chk("ovf set", {31'd0, ovf_err_IFID}, 32'd1);
      tick(0, 0, 0, 0, 32'h0, 32'h0);
      chk("ovf keeps E", inst_out_IFID, E);
      tick(0, 0, 0, 0, 32'h0, 32'h0);
      chk("ovf sticky", {31'd0, ovf_err_IFID}, 32'd1);

      // Counters: 4 stall cycles and 2 flushes after reset
      tick(1, 0, 0, 0, 32'h0, 32'h0);
      repeat (4) tick(0, 0, 1, 0, 32'h0, 32'h0);
      repeat (2) tick(0, 0, 0, 1, 32'h0, 32'h0);
`ifdef IFID_PERF_CNT_EN
      chk("cnt stall", stall_cnt, 32'd4);
      chk("cnt flush", flush_cnt, 32'd2);
      chk("cnt bubble", bubble_cnt, 32'd6);
`else
      chk("cnt stall off", stall_cnt, 32'd0);
      chk("cnt flush off", flush_cnt, 32'd0);
      chk("cnt bubble off", bubble_cnt, 32'd0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic r, v, s, f;
         r = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 9) < 6);
         s = ($urandom_range(0, 9) < 3);
         f = ($urandom_range(0, 9) < 1);
         tick(r, v, s, f, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
